// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares the single EBR block-array port between two requesters: the UART
// host controller (requester 0, "h") and an auxiliary on-chip engine
// (requester 1, "a"). Accesses are serialised. Fairness is round-robin, and
// a requester may keep ownership through a bounded burst of locked grants.
// Read data comes back to the owning requester with a one-cycle valid pulse.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   h_req / a_req      request, held with a stable command until gnt
//   h_lock / a_lock    keep ownership for the next access
//   h_we / a_we        1 = write, 0 = read
//   h_sel / a_sel      EBR block select
//   h_addr / a_addr    word address within the EBR
//   h_wdata / a_wdata  write data
//   h_gnt / a_gnt      one-cycle pulse: command issued to memory this cycle
//   h_rvalid/a_rvalid  one-cycle pulse: registered rdata is valid
//   h_rdata / a_rdata  registered read data per requester
//   mem_select, mem_addr, write_data  registered command to the EBR mux
//   rd_en / wr_en      memory strobes, high only during the ACCESS cycle
//   mem_out            EBR read data, valid the cycle after rd_en
//   busy               high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int MEM_SELECT_BITS = 4,
    parameter int ADDR_BITS       = 8,
    parameter int DATA_BITS       = 16,
    parameter int MAX_BURST       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       h_req,
    input  logic                       h_lock,
    input  logic                       h_we,
    input  logic [MEM_SELECT_BITS-1:0] h_sel,
    input  logic [ADDR_BITS-1:0]       h_addr,
    input  logic [DATA_BITS-1:0]       h_wdata,
    output logic                       h_gnt,
    output logic                       h_rvalid,
    output logic [DATA_BITS-1:0]       h_rdata,
    input  logic                       a_req,
    input  logic                       a_lock,
    input  logic                       a_we,
    input  logic [MEM_SELECT_BITS-1:0] a_sel,
    input  logic [ADDR_BITS-1:0]       a_addr,
    input  logic [DATA_BITS-1:0]       a_wdata,
    output logic                       a_gnt,
    output logic                       a_rvalid,
    output logic [DATA_BITS-1:0]       a_rdata,
    output logic [MEM_SELECT_BITS-1:0] mem_select,
    output logic [ADDR_BITS-1:0]       mem_addr,
    output logic [DATA_BITS-1:0]       write_data,
    output logic                       rd_en,
    output logic                       wr_en,
    input  logic [DATA_BITS-1:0]       mem_out,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic       winner;
    logic       owner;
    logic       owner_we;
    logic       owner_lock;
    logic       last_owner;
    logic       lock_valid;
    logic       lock_owner;
    logic [7:0] burst_cnt;

    // Pick who wins the port if we accept this cycle. A lone requester always
    // wins; with both requesting, an unexhausted lock keeps the current owner,
    // otherwise the port goes to whoever did not have it last.
    always_comb begin
        accept = (state == IDLE) && (h_req || a_req);
        winner = 1'b0;
        if (h_req && !a_req) begin
            winner = 1'b0;
        end else if (!h_req && a_req) begin
            winner = 1'b1;
        end else if (lock_valid && (burst_cnt < BURST_LIMIT)) begin
            winner = lock_owner;
        end else begin
            winner = !last_owner;
        end
    end

    // Next-state logic. ACCESS and RD_WAIT are single cycles; only IDLE can
    // accept, which gives the granted requester its gnt cycle to line up its
    // next command.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  state_next = owner_we ? IDLE : RD_WAIT;
            RD_WAIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: command capture at acceptance, fairness bookkeeping at the
    // end of ACCESS, and read-data return at the end of RD_WAIT. Reset drops
    // any in-flight read so no stale rvalid can appear afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= 1'b0;
            owner_we   <= 1'b0;
            owner_lock <= 1'b0;
            last_owner <= 1'b1;
            lock_valid <= 1'b0;
            lock_owner <= 1'b0;
            burst_cnt  <= 8'd0;
            mem_select <= '0;
            mem_addr   <= '0;
            write_data <= '0;
            h_rdata    <= '0;
            a_rdata    <= '0;
            h_rvalid   <= 1'b0;
            a_rvalid   <= 1'b0;
        end else begin
            h_rvalid <= 1'b0;
            a_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= winner;
                        owner_we   <= winner ? a_we    : h_we;
                        owner_lock <= winner ? a_lock  : h_lock;
                        mem_select <= winner ? a_sel   : h_sel;
                        mem_addr   <= winner ? a_addr  : h_addr;
                        write_data <= winner ? a_wdata : h_wdata;
                    end
                end
                ACCESS: begin
                    last_owner <= owner;
                    if (owner_lock) begin
                        if (lock_valid && (lock_owner == owner)) begin
                            if (burst_cnt != 8'hFF) begin
                                burst_cnt <= burst_cnt + 8'd1;
                            end
                        end else begin
                            lock_valid <= 1'b1;
                            lock_owner <= owner;
                            burst_cnt  <= 8'd1;
                        end
                    end else begin
                        lock_valid <= 1'b0;
                        burst_cnt  <= 8'd0;
                    end
                end
                RD_WAIT: begin
                    if (owner) begin
                        a_rdata  <= mem_out;
                        a_rvalid <= 1'b1;
                    end else begin
                        h_rdata  <= mem_out;
                        h_rvalid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Grants and memory strobes are pure decodes of the ACCESS cycle.
    assign h_gnt = (state == ACCESS) && !owner;
    assign a_gnt = (state == ACCESS) && owner;
    assign wr_en = (state == ACCESS) && owner_we;
    assign rd_en = (state == ACCESS) && !owner_we;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Self-checking bench for bram_port_arbiter. An EBR stand-in answers the
// memory port. A transaction-level reference model predicts each cycle's
// outputs: who is accepted at which clock edge, when that requester's gnt
// and strobes appear, and when its read data returns. Directed scenarios
// run first, followed by randomized traffic in three flavours: host locked
// bursts, unlocked contention and fully random traffic with occasional
// resets.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

   localparam int SB = 4;
   localparam int AB = 8;
   localparam int DB = 16;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          h_req = 1'b0, h_lock = 1'b0, h_we = 1'b0;
   logic [SB-1:0] h_sel = '0;
   logic [AB-1:0] h_addr = '0;
   logic [DB-1:0] h_wdata = '0;
   logic          a_req = 1'b0, a_lock = 1'b0, a_we = 1'b0;
   logic [SB-1:0] a_sel = '0;
   logic [AB-1:0] a_addr = '0;
   logic [DB-1:0] a_wdata = '0;
   logic          h_gnt, h_rvalid, a_gnt, a_rvalid;
   logic [DB-1:0] h_rdata, a_rdata;
   logic [SB-1:0] mem_select;
   logic [AB-1:0] mem_addr;
   logic [DB-1:0] write_data;
   logic          rd_en, wr_en, busy;
   logic [DB-1:0] mem_out = '0;

   int checks_total = 0;
   int checks_passed = 0;

   always #5 clk = ~clk;

   bram_port_arbiter #(
      .MEM_SELECT_BITS(SB), .ADDR_BITS(AB), .DATA_BITS(DB), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .reset(reset),
      .h_req(h_req), .h_lock(h_lock), .h_we(h_we), .h_sel(h_sel),
      .h_addr(h_addr), .h_wdata(h_wdata), .h_gnt(h_gnt),
      .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_sel(a_sel),
      .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt),
      .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .mem_select(mem_select), .mem_addr(mem_addr), .write_data(write_data),
      .rd_en(rd_en), .wr_en(wr_en), .mem_out(mem_out), .busy(busy)
   );

   // EBR stand-in: one-cycle read latency, write on the strobe edge.
   logic [DB-1:0] env_mem [0:4095];
   logic [DB-1:0] ref_mem [0:4095];

   always @(posedge clk) begin
      if (wr_en) env_mem[{mem_select, mem_addr}] <= write_data;
      if (rd_en) mem_out <= env_mem[{mem_select, mem_addr}];
   end

   // Reference model state, kept as transaction facts.
   int            cyc = 0;
   int            free_at = 0;
   bit            g_valid = 0;
   int            g_edge = 0;
   bit            g_who = 0;
   bit            g_we = 0;
   bit            rd_pend = 0;
   int            rd_edge = 0;
   bit            rd_who = 0;
   logic [DB-1:0] rd_data = '0;
   bit            exp_rvh = 0, exp_rva = 0;
   logic [DB-1:0] exp_hr = '0, exp_ar = '0;
   logic [27:0]   exp_bus = '0;
   int            last_own = 1;
   int            lk_own = -1;
   int            cnt = 0;

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("[TB] FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
   endtask

   // Drive one requester's command lines.
   task automatic applyStimulus(input bit who, input bit req, input bit lock, input bit we,
                                input logic [SB-1:0] sel, input logic [AB-1:0] addr,
                                input logic [DB-1:0] wd);
      if (who) begin
         a_req = req; a_lock = lock; a_we = we; a_sel = sel; a_addr = addr; a_wdata = wd;
      end else begin
         h_req = req; h_lock = lock; h_we = we; h_sel = sel; h_addr = addr; h_wdata = wd;
      end
   endtask

   // Model of what happens at one clock edge, driven by the arbitration rules.
   task automatic modelEdge();
      int w;
      bit lk, we;
      logic [SB-1:0] sel;
      logic [AB-1:0] addr;
      logic [DB-1:0] wd;
      exp_rvh = 0;
      exp_rva = 0;
      if (reset) begin
         g_valid = 0; rd_pend = 0; exp_hr = '0; exp_ar = '0; exp_bus = '0;
         last_own = 1; lk_own = -1; cnt = 0; free_at = cyc + 1;
      end else begin
         if (rd_pend && cyc == rd_edge) begin
            rd_pend = 0;
            if (rd_who) begin exp_ar = rd_data; exp_rva = 1; end
            else begin exp_hr = rd_data; exp_rvh = 1; end
         end
         if (cyc >= free_at && (h_req || a_req)) begin
            if (h_req && !a_req) w = 0;
            else if (!h_req && a_req) w = 1;
            else if (lk_own >= 0 && cnt < MB) w = lk_own;
            else w = 1 - last_own;
            lk   = (w == 1) ? a_lock  : h_lock;
            we   = (w == 1) ? a_we    : h_we;
            sel  = (w == 1) ? a_sel   : h_sel;
            addr = (w == 1) ? a_addr  : h_addr;
            wd   = (w == 1) ? a_wdata : h_wdata;
            g_valid = 1; g_edge = cyc; g_who = (w == 1); g_we = we;
            exp_bus = {sel, addr, wd};
            if (we) begin
               ref_mem[{sel, addr}] = wd;
               free_at = cyc + 2;
            end else begin
               rd_pend = 1; rd_edge = cyc + 2; rd_who = (w == 1);
               rd_data = ref_mem[{sel, addr}];
               free_at = cyc + 3;
            end
            last_own = w;
            if (lk) begin
               if (lk_own == w) cnt = (cnt < 255) ? cnt + 1 : 255;
               else begin lk_own = w; cnt = 1; end
            end else begin
               lk_own = -1; cnt = 0;
            end
         end
      end
   endtask

   // Advance one cycle: model the edge, then compare all outputs just after it.
   task automatic stepCycle();
      bit gact, ebusy;
      logic [6:0] exp_strb;
      @(posedge clk);
      modelEdge();
      #1;
      gact  = g_valid && (g_edge == cyc);
      ebusy = g_valid && (cyc <= g_edge + (g_we ? 0 : 1));
      exp_strb = {gact && !g_who, gact && g_who, exp_rvh, exp_rva,
                  gact && !g_we, gact && g_we, ebusy};
      checkOutput("strobes{hg,ag,hv,av,rd,wr,busy}",
                  32'({h_gnt, a_gnt, h_rvalid, a_rvalid, rd_en, wr_en, busy}), 32'(exp_strb));
      checkOutput("h_rdata", 32'(h_rdata), 32'(exp_hr));
      checkOutput("a_rdata", 32'(a_rdata), 32'(exp_ar));
      checkOutput("mem_bus", 32'({mem_select, mem_addr, write_data}), 32'(exp_bus));
      cyc++;
      @(negedge clk);
   endtask

   // Step until the model predicts a grant to 'who', then withdraw its request.
   task automatic waitGrant(input bit who);
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         stepCycle();
         if (g_valid && g_edge == cyc - 1 && g_who == who) seen = 1;
      end
      checkOutput(who ? "wait_a_gnt" : "wait_h_gnt", 32'(seen), 32'd1);
      if (who) a_req = 1'b0; else h_req = 1'b0;
   endtask

   // Random traffic. mode 0: anything goes; 1: both always request unlocked;
   // 2: both always request, host holds lock.
   task automatic randomDrive(input int mode);
      for (int w = 0; w < 2; w++) begin
         bit cur_req, gr, nreq, nlock, nwe;
         cur_req = (w == 1) ? a_req : h_req;
         gr = g_valid && (g_edge == cyc - 1) && (g_who == (w == 1));
         if (gr || !cur_req) begin
            nreq  = (mode != 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
            nlock = (mode == 2) ? (w == 0) : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            nwe   = 1'($urandom_range(0, 1));
            applyStimulus(w == 1, nreq, nlock, nwe, 4'($urandom_range(0, 3)),
                          8'($urandom_range(0, 7)), 16'($urandom));
         end else if (mode == 0 && $urandom_range(0, 99) < 8) begin
            if ($urandom_range(0, 1) == 1) begin
               if (w == 1) a_req = 1'b0; else h_req = 1'b0;
            end else begin
               applyStimulus(w == 1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             4'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 16'($urandom));
            end
         end
      end
      reset = (mode == 0) && ($urandom_range(0, 199) == 0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         env_mem[i] = 16'(i * 40503 + 7);
         ref_mem[i] = 16'(i * 40503 + 7);
      end
      env_mem[12'h005] = 16'h1234; ref_mem[12'h005] = 16'h1234;
      env_mem[12'h006] = 16'h5678; ref_mem[12'h006] = 16'h5678;

      $display("[TB] reset");
      reset = 1'b1;
      repeat (3) stepCycle();
      reset = 1'b0;
      stepCycle();

      $display("[TB] host write then readback");
      applyStimulus(0, 1, 0, 1, 4'd3, 8'h10, 16'hBEEF);
      waitGrant(0);
      applyStimulus(0, 1, 0, 0, 4'd3, 8'h10, 16'h0000);
      waitGrant(0);
      stepCycle();
      stepCycle();
      checkOutput("readback_h_rvalid", 32'(h_rvalid), 32'd1);
      checkOutput("readback_h_rdata", 32'(h_rdata), 32'hBEEF);
      checkOutput("readback_a_rvalid", 32'(a_rvalid), 32'd0);

      $display("[TB] aux read then host read back-to-back");
      applyStimulus(1, 1, 0, 0, 4'd0, 8'h05, 16'h0000);
      waitGrant(1);
      applyStimulus(0, 1, 0, 0, 4'd0, 8'h06, 16'h0000);
      stepCycle();
      stepCycle();
      checkOutput("aux_rdata", 32'(a_rdata), 32'h1234);
      waitGrant(0);
      stepCycle();
      stepCycle();
      checkOutput("host_rdata", 32'(h_rdata), 32'h5678);
      checkOutput("aux_rdata_held", 32'(a_rdata), 32'h1234);

      $display("[TB] request dropped before the sampling edge");
      h_req = 1'b1;
      #2 h_req = 1'b0;
      repeat (3) stepCycle();

      $display("[TB] reset during aux read wait");
      applyStimulus(1, 1, 0, 0, 4'd0, 8'h05, 16'h0000);
      waitGrant(1);
      stepCycle();
      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      applyStimulus(0, 1, 0, 1, 4'd1, 8'h02, 16'hA5A5);
      applyStimulus(1, 1, 0, 1, 4'd1, 8'h03, 16'h5A5A);
      waitGrant(0);
      waitGrant(1);
      stepCycle();

      $display("[TB] random: host locked bursts");
      for (int i = 0; i < 80; i++) begin randomDrive(2); stepCycle(); end
      $display("[TB] random: unlocked contention");
      for (int i = 0; i < 80; i++) begin randomDrive(1); stepCycle(); end
      $display("[TB] random: mixed traffic");
      for (int i = 0; i < 2000; i++) begin randomDrive(0); stepCycle(); end

      h_req = 1'b0; a_req = 1'b0; reset = 1'b0;
      repeat (5) stepCycle();

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
